spi_flash_responder: RTL
========================

# spi_flash_responder

Synthesizable SPI mode-0 flash responder: the target end of the SoC's flash interface (`o_flash_sclk`/`o_flash_cs_n`/`o_flash_mosi`/`i_flash_miso`). It oversamples the master's SPI lines with the system clock, decodes READ (0x03) and JEDEC-ID (0x9F), and serves data bytes from a byte-wide memory read port. It is used as the boot-flash model in chip-level benches and as an FPGA flash emulator, with a ROM/BRAM behind the memory port.

## Interface
Parameters:
- `ADDR_W`, 24: memory address width; the low `ADDR_W` bits of the 24-bit SPI address are used, upper bits ignored.
- `JEDEC_ID`, 24'hEF4016: manufacturer/type/capacity bytes returned for 0x9F, MSB byte first.

Ports:
- `clk` in 1: system clock. Must be ≥16× SCLK frequency.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_sclk` in 1: SPI clock from master, asynchronous to `clk`.
- `i_cs_n` in 1: chip select, active low, asynchronous.
- `i_mosi` in 1: master-out data, asynchronous.
- `o_miso` out 1: responder data.
- `o_miso_oe` out 1: miso output enable, for the pad OEN (active high here).
- `o_mem_req` out 1: memory read request; held until acknowledged.
- `o_mem_addr` out ADDR_W: byte address, stable while `o_mem_req`=1.
- `i_mem_ack` in 1: one-cycle acknowledge; `i_mem_rdata` is valid in the same cycle.
- `i_mem_rdata` in 8: read byte.
- `o_busy` out 1: high whenever the FSM is not IDLE.
- `o_err` out 1: one-cycle pulse on an unsupported opcode or a data underrun.

## Operation
- `i_sclk`, `i_cs_n`, and `i_mosi` each pass through a 2-flop synchronizer. SCLK rise/fall are detected from the synchronized value and its registered copy.
- MOSI is sampled on a detected rise, MSB first. MISO changes only on a detected fall, except for the initial byte load.
- FSM states and transitions:
  - IDLE: stays here while cs_n=1. On cs_n falling, go to CMD with the bit count cleared.
  - CMD (8 rises): 0x03 goes to ADDR. 0x9F goes to JEDEC. 0x0B goes to ADDR only with fast read compiled in. Any other opcode pulses `o_err` and goes to IGNORE.
  - ADDR (24 rises): the address is assembled MSB first. On the 24th rise, go to DATA, or to DUMMY for 0x0B.
  - DUMMY (8 rises): go to DATA. MISO stays undriven during this state.
  - DATA: on entry, issue `o_mem_req` at the current address. When ack arrives, load the shift register, drive bit 7, assert `o_miso_oe`, increment the address, and immediately request the next byte into a 1-byte holding register. On the 8th fall of each byte, move holding→shift and issue the next request. If the holding register is empty at that fall, pulse `o_err`, shift out 8'h00, and keep streaming.
  - JEDEC: shift out the 3 ID bytes, then 8'h00 for as long as cs_n stays low.
  - IGNORE: MISO is not driven; wait for cs_n high.
- cs_n high, detected in any state, forces IDLE within 1 clk: `o_miso_oe`=0, `o_miso`=0, counters cleared, holding register invalidated.
- An outstanding `o_mem_req` stays asserted until `i_mem_ack`, even after cs_n rises. That late data is discarded.
- Address increment wraps modulo 2^ADDR_W.

## Timing
- Reset values: `o_miso`=0, `o_miso_oe`=0, `o_mem_req`=0, `o_mem_addr`=0, `o_busy`=0, `o_err`=0. FSM is in IDLE.
- Edge-detect latency is 3 clk from the pin edge: 2 synchronizer flops plus 1 edge register.
- `o_mem_req` rises 1 clk after the 32nd rise is detected (40th for 0x0B).
- Memory ack latency must be ≤ 8 clk from `o_mem_req` so that bit 7 is on MISO before the master's next rise.
- MISO updates 1 clk after each detected fall.
- `o_busy` rises 1 clk after cs_n low is detected and falls 1 clk after cs_n high is detected.

## Configuration
- `SPI_RESP_FAST_READ_EN` defined: opcode 0x0B (FAST READ) is accepted. Sequence is 24 address bits, then 8 dummy clocks, then data identical to 0x03.
- Not defined: 0x0B is treated as an unsupported opcode (`o_err` pulse, IGNORE), and the DUMMY state logic is absent.

## Test plan
- READ 0x03, addr 0x000010, 4 bytes, memory holds mem[i]=i, SCLK=clk/16 → MISO bytes 0x10,0x11,0x12,0x13; `o_mem_addr` sequence 0x10…0x14; `o_err` never pulses.
- JEDEC 0x9F with 5 bytes clocked → EF 40 16 00 00; `o_mem_req` never asserted.
- Opcode 0xAB → one `o_err` pulse; `o_miso_oe`=0 until cs_n high; next READ transaction works normally.
- READ at address 2^ADDR_W−1 (ADDR_W=8, addr 0x0000FF), 2 bytes → mem[0xFF] then mem[0x00].
- cs_n raised mid-byte in DATA, with ack delayed 6 clk → `o_miso_oe`=0 within 4 clk of the pin edge; late ack consumed; `o_busy`=0; an immediate new READ returns correct data.
- With `SPI_RESP_FAST_READ_EN`: 0x0B, addr 0x20, 8 dummy clocks → mem[0x20] on the first data byte. Without the macro: same stimulus → `o_err` pulse and MISO undriven.

Source files
------------

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash target that decodes READ (0x03) and
// JEDEC-ID (0x9F) and streams data from a byte-wide memory read port.
// Optional feature macro: SPI_RESP_FAST_READ_EN enables FAST READ (0x0B),
// which adds 8 dummy clocks between the address and the data phase.
// All SPI pins are oversampled by clk, which must run at least 16x SCLK.

module spi_flash_responder #(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_sclk,
    input  logic              i_cs_n,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_miso_oe,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_busy,
    output logic              o_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_JEDEC  = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;
`ifdef SPI_RESP_FAST_READ_EN
    localparam logic [2:0] ST_DUMMY  = 3'd6;
`endif

    logic sclk_s1, sclk_s2, sclk_d;
    logic cs_s1, cs_s2;
    logic mosi_s1, mosi_s2;

    logic [2:0]  state;
    logic [4:0]  bit_cnt;
    logic [22:0] in_sh;      // incoming opcode/address bits, newest in bit 0
    logic [7:0]  out_sh;     // outgoing byte, bit 7 is on MISO
    logic [7:0]  hold;
    logic        hold_v;
    logic [1:0]  jedec_idx;  // next JEDEC byte to present
    logic        err_q;
`ifdef SPI_RESP_FAST_READ_EN
    logic        fast_q;
`endif

    logic              sclk_rise, sclk_fall;
    logic              ack_fire;
    logic [7:0]        op_byte;
    logic [23:0]       addr_full;
    logic [ADDR_W-1:0] addr_inc;

    // Two-flop synchronizers plus the registered SCLK copy used for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= i_sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            cs_s1   <= i_cs_n;
            cs_s2   <= cs_s1;
            mosi_s1 <= i_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;
    assign ack_fire  = i_mem_ack & o_mem_req;
    assign op_byte   = {in_sh[6:0], mosi_s2};
    assign addr_full = {in_sh, mosi_s2};
    assign addr_inc  = o_mem_addr + ADDR_W'(1);

    // Protocol FSM, shift registers and memory handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 5'd0;
            in_sh      <= 23'd0;
            out_sh     <= 8'h00;
            hold       <= 8'h00;
            hold_v     <= 1'b0;
            jedec_idx  <= 2'd0;
            err_q      <= 1'b0;
            o_miso_oe  <= 1'b0;
            o_mem_req  <= 1'b0;
            o_mem_addr <= '0;
`ifdef SPI_RESP_FAST_READ_EN
            fast_q     <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
            // Outside an active data phase an ack only retires the request;
            // its data belongs to an aborted transfer and is dropped.
            if (ack_fire && (cs_s2 || state != ST_DATA)) begin
                o_mem_req <= 1'b0;
            end

            if (cs_s2) begin
                state     <= ST_IDLE;
                bit_cnt   <= 5'd0;
                out_sh    <= 8'h00;
                hold_v    <= 1'b0;
                jedec_idx <= 2'd0;
                o_miso_oe <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_CMD;
                        bit_cnt <= 5'd0;
                    end

                    ST_CMD: begin
                        if (sclk_rise) begin
                            in_sh   <= {in_sh[21:0], mosi_s2};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= 5'd0;
                                case (op_byte)
                                    8'h03: begin
                                        state <= ST_ADDR;
`ifdef SPI_RESP_FAST_READ_EN
                                        fast_q <= 1'b0;
`endif
                                    end
`ifdef SPI_RESP_FAST_READ_EN
                                    8'h0B: begin
                                        state  <= ST_ADDR;
                                        fast_q <= 1'b1;
                                    end
`endif
                                    8'h9F: begin
                                        state     <= ST_JEDEC;
                                        out_sh    <= JEDEC_ID[23:16];
                                        o_miso_oe <= 1'b1;
                                        jedec_idx <= 2'd1;
                                    end
                                    default: begin
                                        state <= ST_IGNORE;
                                        err_q <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end

                    ST_ADDR: begin
                        if (sclk_rise) begin
                            in_sh   <= {in_sh[21:0], mosi_s2};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt    <= 5'd0;
                                o_mem_addr <= ADDR_W'(addr_full);
`ifdef SPI_RESP_FAST_READ_EN
                                if (fast_q) begin
                                    state <= ST_DUMMY;
                                end else begin
                                    state     <= ST_DATA;
                                    o_mem_req <= 1'b1;
                                end
`else
                                state     <= ST_DATA;
                                o_mem_req <= 1'b1;
`endif
                            end
                        end
                    end

`ifdef SPI_RESP_FAST_READ_EN
                    ST_DUMMY: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt   <= 5'd0;
                                state     <= ST_DATA;
                                o_mem_req <= 1'b1;
                            end
                        end
                    end
`endif

                    // bit_cnt counts data rises; the fall that follows the 8th rise is
                    // the byte boundary. The fall right after entry sees bit_cnt=0.
                    ST_DATA: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                        if (sclk_fall && bit_cnt == 5'd8) begin
                            bit_cnt   <= 5'd0;
                            o_miso_oe <= 1'b1;
                            o_mem_req <= 1'b1;
                            if (hold_v) begin
                                out_sh <= hold;
                                hold_v <= 1'b0;
                            end else if (ack_fire) begin
                                out_sh     <= i_mem_rdata;
                                o_mem_addr <= addr_inc;
                            end else begin
                                out_sh <= 8'h00;
                                err_q  <= 1'b1;
                            end
                        end else begin
                            if (sclk_fall && bit_cnt != 5'd0) begin
                                out_sh <= {out_sh[6:0], 1'b0};
                            end
                            if (ack_fire) begin
                                o_mem_addr <= addr_inc;
                                if (!o_miso_oe) begin
                                    // first byte goes straight to MISO, request stays up
                                    out_sh    <= i_mem_rdata;
                                    o_miso_oe <= 1'b1;
                                end else begin
                                    hold      <= i_mem_rdata;
                                    hold_v    <= 1'b1;
                                    o_mem_req <= 1'b0;
                                end
                            end
                        end
                    end

                    ST_JEDEC: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                        if (sclk_fall && bit_cnt == 5'd8) begin
                            bit_cnt <= 5'd0;
                            case (jedec_idx)
                                2'd1: begin
                                    out_sh    <= JEDEC_ID[15:8];
                                    jedec_idx <= 2'd2;
                                end
                                2'd2: begin
                                    out_sh    <= JEDEC_ID[7:0];
                                    jedec_idx <= 2'd3;
                                end
                                default: out_sh <= 8'h00;
                            endcase
                        end else if (sclk_fall && bit_cnt != 5'd0) begin
                            out_sh <= {out_sh[6:0], 1'b0};
                        end
                    end

                    ST_IGNORE: begin
                        state <= ST_IGNORE;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_miso = out_sh[7];
    assign o_err  = err_q;
    assign o_busy = (state != ST_IDLE);

endmodule
